md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_sequencer_if.sv | 38 +++
 rtl/md_arith.sv | 56 +++++
 rtl/md_sequencer.sv | 128 ++++++++++++
 tb/tb_md_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide sequencer.
//   Op encoding on the 3-bit op field, FSM state encoding and the default
//   busy latencies for mult/multu and div/divu.
//   No ports (package).
package md_pkg;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // mult/multu/div/divu occupy the unit for several cycles
   function automatic logic md_is_long(input logic [2:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if -- E/D-stage handshake bundle for the MD sequencer.
//   start/op/a/b : issue of an MD op from the E stage
//   use_md       : D-stage instruction is MD-class
//   flush        : (only with MD_FLUSH_EN) abort in-flight op / block issue
//   hi/lo        : architectural HI/LO
//   busy/stall/done : status back to the pipeline
// Modports: master (pipeline side), slave (sequencer side).
interface md_sequencer_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        use_md;
`ifdef MD_FLUSH_EN
   logic        flush;
`endif
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;
   logic        done;

   modport master (
`ifdef MD_FLUSH_EN
      output flush,
`endif
      output start, op, a, b, use_md,
      input  hi, lo, busy, stall, done
   );

   modport slave (
`ifdef MD_FLUSH_EN
      input  flush,
`endif
      input  start, op, a, b, use_md,
      output hi, lo, busy, stall, done
   );
endinterface

// File: rtl/md_arith.sv
// md_arith -- combinational MD datapath.
//   i_op   : op code (md_pkg encoding)
//   i_a    : rs / dividend
//   i_b    : rt / divisor
//   o_res  : {hi, lo}; product for mult ops, {remainder, quotient} for divs
//   o_div0 : divide op with a zero divisor (result must not be written)
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_res,
   output logic        o_div0
);

   logic [63:0] w_sa, w_sb, w_smul, w_umul;
   logic [31:0] w_bsafe, w_abs_a, w_abs_b;
   logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;

   // Sign-extended operands: the low 64 bits of the unsigned product equal
   // the signed 64-bit product.
   assign w_sa   = {{32{i_a[31]}}, i_a};
   assign w_sb   = {{32{i_b[31]}}, i_b};
   assign w_smul = w_sa * w_sb;
   assign w_umul = {32'd0, i_a} * {32'd0, i_b};

   // Divisor forced non-zero so the divider never sees 0; the result is
   // discarded via o_div0 in that case anyway.
   assign w_bsafe = (i_b == 32'd0) ? 32'd1 : i_b;

   // Signed divide on magnitudes. |0x80000000| fits as unsigned, so
   // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
   assign w_abs_a  = i_a[31] ? (~i_a + 32'd1) : i_a;
   assign w_abs_b  = i_b[31] ? (~i_b + 32'd1) : w_bsafe;
   assign w_sq_mag = w_abs_a / w_abs_b;
   assign w_sr_mag = w_abs_a % w_abs_b;
   assign w_sq     = (i_a[31] ^ i_b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
   assign w_sr     = i_a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

   assign w_uq = i_a / w_bsafe;
   assign w_ur = i_a % w_bsafe;

   always_comb begin
      o_res  = 64'd0;
      o_div0 = md_is_div(i_op) && (i_b == 32'd0);
      case (i_op)
         OP_MULT:  o_res = w_smul;
         OP_MULTU: o_res = w_umul;
         OP_DIV:   o_res = {w_sr, w_sq};
         OP_DIVU:  o_res = {w_ur, w_uq};
         default:  o_res = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer -- multi-cycle HI/LO sequencer for MIPS mult/div.
//   Optional feature macro: MD_FLUSH_EN (adds bus.flush).
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : md_sequencer_if.slave (start/op/a/b/use_md[/flush] in,
//             hi/lo/busy/stall/done out)
// The result is computed at issue and parked in a pending register; the
// counter only models latency, HI/LO update when it expires.
module md_sequencer
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic           clk,
   input  logic           reset_n,
   md_sequencer_if.slave  bus
);

   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = (MAX_N < 2) ? 1 : $clog2(MAX_N);
   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e        r_state, w_state_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [63:0]      r_pend;
   logic             r_pend_wr;
   logic [31:0]      r_hi, r_lo;
   logic             r_done;

   logic [63:0]      w_res;
   logic             w_div0;
   logic             w_flush;
   logic             w_load, w_commit, w_mthi, w_mtlo, w_done_nx;

`ifdef MD_FLUSH_EN
   assign w_flush = bus.flush;
`else
   assign w_flush = 1'b0;
`endif

   md_arith u_arith (
      .i_op   (bus.op),
      .i_a    (bus.a),
      .i_b    (bus.b),
      .o_res  (w_res),
      .o_div0 (w_div0)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_load     = 1'b0;
      w_commit   = 1'b0;
      w_mthi     = 1'b0;
      w_mtlo     = 1'b0;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && !w_flush) begin
               if (md_is_long(bus.op)) begin
                  w_load     = 1'b1;
                  w_state_nx = ST_BUSY;
                  w_cnt_nx   = md_is_div(bus.op) ? DIV_LD : MULT_LD;
               end else if (bus.op == OP_MTHI) begin
                  w_mthi = 1'b1;
               end else if (bus.op == OP_MTLO) begin
                  w_mtlo = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            // flush outranks expiry: no write, no done
            if (w_flush) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt == '0) begin
               w_state_nx = ST_IDLE;
               w_commit   = r_pend_wr;
               w_done_nx  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend    <= '0;
         r_pend_wr <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_done_nx;
         if (w_load) begin
            r_pend    <= w_res;
            r_pend_wr <= !w_div0;
         end
         if (w_commit) begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
         end
         if (w_mthi) r_hi <= bus.a;
         if (w_mtlo) r_lo <= bus.a;
      end
   end

   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;
   assign bus.busy  = (r_state == ST_BUSY);
   assign bus.done  = r_done;
   assign bus.stall = bus.use_md & ((r_state == ST_BUSY) | (bus.start & md_is_long(bus.op)));

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer -- directed + random checks of md_sequencer against a
// cycle-count reference model (remaining-busy-cycles + pending result).
module tb_md_sequencer;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   logic tb_flush;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   md_sequencer_if bus();
`ifdef MD_FLUSH_EN
   assign bus.flush = tb_flush;
`endif

   md_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   // reference model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pwr, m_done;
   int          m_left;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic fl();
`ifdef MD_FLUSH_EN
      return tb_flush;
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_reset();
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_done = 0; m_left = 0;
   endtask

   task automatic m_update();
      logic d;
      longint sp;
      longint unsigned up;
      int sa, sb, q, r;
      if (!reset_n) begin m_reset(); return; end
      d = 1'b0;
      if (m_left > 0) begin
         if (fl()) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
               d = 1'b1;
            end
         end
      end else if (bus.start && !fl()) begin
         case (bus.op)
            3'd1: begin
               sp = longint'($signed(bus.a)) * longint'($signed(bus.b));
               {m_phi, m_plo} = sp; m_pwr = 1; m_left = MD_MULT_CYCLES;
            end
            3'd2: begin
               up = longint'({32'd0, bus.a}) * longint'({32'd0, bus.b});
               {m_phi, m_plo} = up; m_pwr = 1; m_left = MD_MULT_CYCLES;
            end
            3'd3: begin
               sa = $signed(bus.a); sb = $signed(bus.b);
               m_pwr = (sb != 0); m_left = MD_DIV_CYCLES;
               if (sb == -1 && sa == 32'sh80000000) begin q = sa; r = 0; end
               else if (sb != 0) begin q = sa / sb; r = sa % sb; end
               else begin q = 0; r = 0; end
               m_plo = q; m_phi = r;
            end
            3'd4: begin
               m_pwr = (bus.b != 0); m_left = MD_DIV_CYCLES;
               if (bus.b != 0) begin m_plo = bus.a / bus.b; m_phi = bus.a % bus.b; end
               else begin m_plo = 0; m_phi = 0; end
            end
            3'd5: m_hi = bus.a;
            3'd6: m_lo = bus.a;
            default: ;
         endcase
      end
      m_done = d;
   endtask

   // check current cycle against model, then advance one clock
   task automatic step();
      logic exp_stall;
      #1;
      exp_stall = bus.use_md & ((m_left > 0) | (bus.start & (bus.op >= 3'd1) & (bus.op <= 3'd4)));
      chk("busy",  bus.busy,  m_left > 0);
      chk("done",  bus.done,  m_done);
      chk("hi",    bus.hi,    m_hi);
      chk("lo",    bus.lo,    m_lo);
      chk("stall", bus.stall, exp_stall);
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
      step();
      bus.start = 0;
   endtask

   // run while busy, bounded; returns number of busy cycles seen
   task automatic drain(output int n);
      n = 0;
      while (bus.busy && n < 40) begin step(); n++; end
   endtask

   initial begin
      int n, st;
      logic [31:0] sv_hi, sv_lo;
      reset_n = 0; tb_flush = 0;
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.use_md = 0;
      m_reset();
      #1;
      chk("rst_hi", bus.hi, 0); chk("rst_lo", bus.lo, 0);
      chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0);
      @(negedge clk); step(); step();
      reset_n = 1;
      step();

      // signed mult, 5 busy cycles, single done
      issue(OP_MULT, 32'd3, 32'hFFFFFFFE);
      drain(n);
      chk("r031_nbusy", n, 5);
      chk("r031_done", bus.done, 1);
      chk("r031_hi", bus.hi, 32'hFFFFFFFF);
      chk("r031_lo", bus.lo, 32'hFFFFFFFA);
      step();
      chk("r031_done_off", bus.done, 0);

      // unsigned mult
      issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
      drain(n); step();
      chk("r032_hi", bus.hi, 32'h00000001);
      chk("r032_lo", bus.lo, 32'hFFFFFFFE);

      // signed div with use_md held: stall on issue + 10 busy cycles
      bus.use_md = 1; st = 0;
      bus.start = 1; bus.op = OP_DIV; bus.a = 32'hFFFFFFF9; bus.b = 32'd2;
      #1 if (bus.stall) st++;
      step(); bus.start = 0;
      n = 0;
      while (bus.busy && n < 40) begin #1 if (bus.stall) st++; step(); n++; end
      #1 if (bus.stall) st++;
      chk("r033_stall_cnt", st, 11);
      chk("r033_lo", bus.lo, 32'hFFFFFFFD);
      chk("r033_hi", bus.hi, 32'hFFFFFFFF);
      bus.use_md = 0;
      step();

      // 0x80000000 / -1
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      drain(n); step();
      chk("r019_lo", bus.lo, 32'h80000000);
      chk("r019_hi", bus.hi, 32'h0);

      // divide by zero after mthi
      issue(OP_MTHI, 32'h1234, 32'd0);
      chk("r021_busy", bus.busy, 0);
      sv_lo = bus.lo;
      issue(OP_DIVU, 32'h55, 32'd0);
      drain(n);
      chk("r034_nbusy", n, 10);
      chk("r034_done", bus.done, 1);
      chk("r034_hi", bus.hi, 32'h1234);
      chk("r034_lo", bus.lo, sv_lo);
      step();

      // reset in busy cycle 3 of a mult
      issue(OP_MULT, 32'h7, 32'h9);
      step(); step();
      #2 reset_n = 0;
      #1;
      chk("r035_hi", bus.hi, 0); chk("r035_lo", bus.lo, 0);
      chk("r035_busy", bus.busy, 0); chk("r035_done", bus.done, 0);
      m_reset();
      @(negedge clk);
      step();
      bus.start = 1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6;
      reset_n = 1;
      step(); bus.start = 0;
      chk("r026_busy", bus.busy, 1);
      drain(n); step();
      chk("r026_lo", bus.lo, 32'd30);

`ifdef MD_FLUSH_EN
      // flush in div busy cycle 4
      issue(OP_MULT, 32'h11, 32'h3);
      drain(n); step();
      sv_hi = bus.hi; sv_lo = bus.lo;
      issue(OP_DIV, 32'd100, 32'd7);
      step(); step(); step();
      tb_flush = 1; step(); tb_flush = 0;
      chk("r036_busy", bus.busy, 0);
      chk("r036_done", bus.done, 0);
      chk("r036_hi", bus.hi, sv_hi);
      chk("r036_lo", bus.lo, sv_lo);
      issue(OP_MULT, 32'd4, 32'd4);
      drain(n);
      chk("r036_nbusy", n, 5);
      chk("r036_lo2", bus.lo, 32'd16);
      step();
`else
      sv_hi = 0;
      if (sv_hi != 0) $display("unreachable");
`endif

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.start  = ($urandom_range(0, 2) == 0);
         bus.op     = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: bus.a = 32'h80000000;
            1: bus.a = 32'hFFFFFFFF;
            default: bus.a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: bus.b = 32'd0;
            1: bus.b = 32'hFFFFFFFF;
            2: bus.b = 32'($urandom_range(1, 9));
            default: bus.b = $urandom;
         endcase
         bus.use_md = 1'($urandom_range(0, 1));
`ifdef MD_FLUSH_EN
         tb_flush = ($urandom_range(0, 15) == 0);
`endif
         step();
      end
      bus.start = 0; tb_flush = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
